spi_slave: RTL and testbench

Serial front end of the SPI-slave/single-port-RAM subsystem. Deserialises MOSI frames under SS_n into 10-bit command words and pulses `rx_valid` to the RAM. For read-data commands it captures the RAM's 8-bit response on `tx_valid` and shifts it out on MISO, MSB first. Read-address and read-data frames strictly alternate, tracked by an internal flag.

---
 rtl/spi_slave.sv | 121 ++++++++++++
 tb/tb_spi_slave.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI slave front end for the single-port RAM subsystem.
// Deserialises a command bit plus a (DATA_W+2)-bit word per SS_n frame,
// strobes the word to the RAM, and for read-data frames shifts the RAM's
// response out on MISO, MSB first.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MOSI,
  input  logic              SS_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam int CNT_W = $clog2(DATA_W + 4);
  // Counter value on the edge that samples the last word bit.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);
  // Counter value on the RAM capture edge (tx_valid not looked at yet).
  localparam logic [CNT_W-1:0] CAPTURE  = CNT_W'(DATA_W + 2);
  // Counter value from which tx_valid is honoured.
  localparam logic [CNT_W-1:0] TX_PHASE = CNT_W'(DATA_W + 3);
  // Bits still to shift after the MSB has been driven.
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic              rd_addr_seen;
  logic [DATA_W-1:0] tx_sr;
  logic [CNT_W-1:0]  tx_cnt;
  logic              tx_busy;
  logic              tx_done;

  // Frame FSM: receive shift, RAM strobe, read alternation flag and MISO shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      cnt          <= '0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      tx_sr        <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        // Frame ended (or aborted): drop any partial word and silence MISO.
        state   <= IDLE;
        MISO    <= 1'b0;
        tx_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            MISO <= 1'b0;
            if (!SS_n) begin
              state   <= CHK_CMD;
              cnt     <= '0;
              sr      <= '0;
              tx_busy <= 1'b0;
              tx_done <= 1'b0;
            end
          end
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          default: begin
            if (cnt <= LAST_BIT) begin
              sr  <= {sr[DATA_W-1:0], MOSI};
              cnt <= cnt + 1'b1;
              if (cnt == LAST_BIT) begin
                rx_data  <= {sr, MOSI};
                rx_valid <= 1'b1;
                if (state == READ_ADD)       rd_addr_seen <= 1'b1;
                else if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end
            end else if (cnt == CAPTURE) begin
              cnt <= TX_PHASE;
            end else if (state == READ_DATA) begin
              if (tx_busy) begin
                if (tx_cnt == TX_LAST) begin
                  MISO    <= 1'b0;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                end else begin
                  MISO   <= tx_sr[DATA_W-1];
                  tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                  tx_cnt <= tx_cnt + 1'b1;
                end
              end else if (!tx_done && tx_valid) begin
                // Single load per frame; a lingering tx_valid is ignored later.
                MISO    <= tx_data[DATA_W-1];
                tx_sr   <= {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt  <= '0;
                tx_busy <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed test of spi_slave with a small single-port RAM model.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       MOSI;
  logic       SS_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;

  int asserts = 0;
  int failures = 0;

  // RAM model
  logic [7:0] mem [256];
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [7:0] ram_dout;
  logic       ram_tv;
  logic       hold_tv;

  assign tx_data  = ram_dout;
  assign tx_valid = ram_tv | hold_tv;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always @(posedge clk) begin
    ram_tv <= 1'b0;
    if (rx_valid) begin
      case (rx_data[9:8])
        2'b00: wr_addr <= rx_data[7:0];
        2'b01: mem[wr_addr] <= rx_data[7:0];
        2'b10: rd_addr <= rx_data[7:0];
        default: begin
          ram_dout <= mem[rd_addr];
          ram_tv   <= 1'b1;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame: E0 select, E1 command bit, E2..E11 word, E12 capture,
  // then (read data) E13..E21 MISO burst, extra low edges, then SS_n high.
  task automatic frame(input logic cmd, input logic [9:0] w, input logic rd,
                       input logic [7:0] exp_byte, input int extra);
    SS_n = 1'b0; MOSI = 1'b0;
    tick();
    MOSI = cmd;
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      tick();
      if (i == 1) check("rx_valid_early", rx_valid, 1'b0);
    end
    check("rx_valid_pulse", rx_valid, 1'b1);
    check("rx_data", rx_data, w);
    MOSI = 1'b1;
    tick();
    check("rx_valid_end", rx_valid, 1'b0);
    check("miso_capture", MISO, 1'b0);
    if (rd) begin
      for (int k = 0; k < 9; k++) begin
        tick();
        check($sformatf("miso_bit%0d", k), MISO, (k < 8) ? exp_byte[7-k] : 1'b0);
      end
    end
    for (int k = 0; k < extra; k++) begin
      tick();
      check("miso_quiet", MISO, 1'b0);
      check("rx_valid_quiet", rx_valid, 1'b0);
    end
    SS_n = 1'b1;
    tick();
    check("miso_idle", MISO, 1'b0);
    $display("frame cmd=%0d word=0x%03h rd=%0d flag=%0d", cmd, w, rd, dut.rd_addr_seen);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; hold_tv = 1'b0;
    ram_tv = 1'b0; ram_dout = 8'h00; wr_addr = 8'h00; rd_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_miso", MISO, 1'b0);
    check("reset_rx_data", rx_data, 10'h000);
    check("reset_flag", dut.rd_addr_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Writes: address 5 then data 0xAA
    frame(1'b0, 10'h005, 1'b0, 8'h00, 0);
    check("write_flag", dut.rd_addr_seen, 1'b0);
    frame(1'b0, 10'h1AA, 1'b0, 8'h00, 0);
    check("write_flag2", dut.rd_addr_seen, 1'b0);

    // Read pair
    frame(1'b1, 10'h205, 1'b0, 8'h00, 0);
    check("rdadd_flag", dut.rd_addr_seen, 1'b1);
    frame(1'b1, 10'h300, 1'b1, 8'hAA, 0);
    check("rddata_flag", dut.rd_addr_seen, 1'b0);

    // Abort after 6 word bits
    SS_n = 1'b0; MOSI = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      MOSI = i[0];
      tick();
    end
    SS_n = 1'b1;
    tick();
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_miso", MISO, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_quiet", rx_valid, 1'b0);
    end
    $display("abort frame after 6 bits");
    frame(1'b0, 10'h003, 1'b0, 8'h00, 0);
    frame(1'b0, 10'h155, 1'b0, 8'h00, 0);

    // Alternation: read-add, read-data, read-add
    frame(1'b1, 10'h203, 1'b0, 8'h00, 0);
    check("alt1_flag", dut.rd_addr_seen, 1'b1);
    frame(1'b1, 10'h300, 1'b1, 8'h55, 0);
    check("alt2_flag", dut.rd_addr_seen, 1'b0);
    frame(1'b1, 10'h205, 1'b0, 8'h00, 0);
    check("alt3_flag", dut.rd_addr_seen, 1'b1);

    // Stale tx_valid held through the whole read-data frame
    hold_tv = 1'b1;
    frame(1'b1, 10'h3C3, 1'b1, 8'hAA, 4);
    hold_tv = 1'b0;
    check("stale_flag", dut.rd_addr_seen, 1'b0);

    // Reset mid-frame after 9 word bits
    SS_n = 1'b0; MOSI = 1'b0;
    tick();
    MOSI = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      MOSI = 1'b1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rx_valid", rx_valid, 1'b0);
    check("arst_miso", MISO, 1'b0);
    check("arst_rx_data", rx_data, 10'h000);
    check("arst_flag", dut.rd_addr_seen, 1'b0);
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst_quiet", rx_valid, 1'b0);
    end
    $display("async reset mid-frame");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
